// File: rtl/rca_config_types.sv
// Shared types for the RCA configuration path.
// Provides the configuration kind enumeration, the entry layout used by the
// decode side (default field widths), the sequencer FSM state type and a
// helper that maps a kind to its one-hot regfile write enable.
package rca_config_types;

  localparam int CFG_KIND_W = 2;
  localparam int CFG_RCA_W  = 2;
  localparam int CFG_ADDR_W = 8;
  localparam int CFG_DATA_W = 8;

  typedef enum logic [CFG_KIND_W-1:0] {
    CFG_CPU_REG    = 2'd0,
    CFG_GRID_MUX   = 2'd1,
    CFG_IO_MUX     = 2'd2,
    CFG_RESULT_MUX = 2'd3
  } rca_cfg_kind_t;

  // Field order matches the flat packing used inside the sequencer queue.
  typedef struct packed {
    rca_cfg_kind_t         kind;
    logic [CFG_RCA_W-1:0]  rca_sel;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } rca_cfg_entry_t;

  typedef enum logic {
    SEQ_RUN   = 1'b0,
    SEQ_FLUSH = 1'b1
  } rca_seq_state_t;

  function automatic logic [3:0] kind_onehot(input logic [CFG_KIND_W-1:0] kind);
    return 4'b0001 << kind;
  endfunction

endpackage

// File: rtl/rca_cfg_fifo.sv
// Synchronous-reset FIFO used as the configuration write queue.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          clears both pointers (queued contents discarded)
//   push, din      write one entry when not full
//   pop            advance read pointer when not empty
//   dout           head entry (combinational read of the head slot)
//   full, empty    status, distinguished by the pointer MSB
module rca_cfg_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Extra MSB on each pointer: equal index with differing MSB means wrapped once.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign dout  = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/rca_config_sequencer.sv
// Buffers RCA configuration writes and drains them one per cycle into the
// RCA configuration register file, while counting outstanding writes per RCA
// so issue can hold rca_use instructions on an RCA still being configured.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_valid/cfg_ready          request handshake from decode/issue
//   cfg_kind/rca_sel/addr/data   configuration write fields
//   wr_hold                      regfile busy, suppresses the pop
//   wr_en (one-hot by kind), wr_rca_sel, wr_addr, wr_data
//                                registered regfile write port
//   use_rca_sel/use_ready        query: no outstanding config for that RCA
//   flush                        discard all queued configuration
//   busy                         queue non-empty or write in flight
module rca_config_sequencer
  import rca_config_types::*;
#(
  parameter int NUM_RCAS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  localparam int RCA_W     = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CFG_KIND_W-1:0] cfg_kind,
  input  logic [RCA_W-1:0]      cfg_rca_sel,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  wr_hold,
  output logic [3:0]            wr_en,
  output logic [RCA_W-1:0]      wr_rca_sel,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic [RCA_W-1:0]      use_rca_sel,
  output logic                  use_ready,
  input  logic                  flush,
  output logic                  busy
);

  localparam int ENTRY_W = CFG_KIND_W + RCA_W + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 2);

  rca_seq_state_t state;
  logic           run;
  logic           accept;
  logic           pop_fire;
  logic           fifo_full;
  logic           fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  logic [CFG_KIND_W-1:0] head_kind;
  logic [RCA_W-1:0]      head_rca;
  logic [ADDR_W-1:0]     head_addr;
  logic [DATA_W-1:0]     head_data;

  logic [CNT_W-1:0] pending [NUM_RCAS];

  // Stage p0: accept and pop decisions
  assign run       = (state == SEQ_RUN);
  assign cfg_ready = !rst && run && !fifo_full && !flush;
  assign accept    = cfg_valid && cfg_ready;
  assign pop_fire  = !rst && run && !flush && !fifo_empty && !wr_hold;

  assign push_entry = {cfg_kind, cfg_rca_sel, cfg_addr, cfg_data};
  assign {head_kind, head_rca, head_addr, head_data} = head_entry;

  rca_cfg_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (accept),
    .din   (push_entry),
    .pop   (pop_fire),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage p1: registered write port, pending counters and FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEQ_RUN;
      wr_en      <= '0;
      wr_rca_sel <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      for (int r = 0; r < NUM_RCAS; r++)
        pending[r] <= '0;
    end else if (run && flush) begin
      state <= SEQ_FLUSH;
      wr_en <= '0;
      for (int r = 0; r < NUM_RCAS; r++)
        pending[r] <= '0;
    end else if (!run) begin
      state <= SEQ_RUN;
      wr_en <= '0;
    end else begin
      if (pop_fire) begin
        wr_en      <= kind_onehot(head_kind);
        wr_rca_sel <= head_rca;
        wr_addr    <= head_addr;
        wr_data    <= head_data;
      end else begin
        wr_en <= '0;
      end
      // A write retiring and a new accept on the same RCA cancel out.
      for (int r = 0; r < NUM_RCAS; r++) begin
        if (accept && (cfg_rca_sel == RCA_W'(r)) &&
            !((wr_en != '0) && (wr_rca_sel == RCA_W'(r))))
          pending[r] <= pending[r] + CNT_W'(1);
        else if (!(accept && (cfg_rca_sel == RCA_W'(r))) &&
                 (wr_en != '0) && (wr_rca_sel == RCA_W'(r)))
          pending[r] <= pending[r] - CNT_W'(1);
      end
    end
  end

  assign use_ready = (pending[use_rca_sel] == '0);
  assign busy      = !fifo_empty || (wr_en != '0);

endmodule

// File: doc/rca_config_sequencer.md
# rca_config_sequencer

Buffers RCA configuration writes (CPU register address, grid mux, IO mux and result mux selects) decoded at issue, and drains them one per cycle into the RCA configuration register file. It also tracks outstanding configuration writes per RCA, so the issue logic can hold any `rca_use` instruction whose target RCA is still being reconfigured. It sits between the RCA decode/issue path and `rca_config_regs`, inside the RCA unit.

## Interface
Parameters:
- `NUM_RCAS`, 4: number of selectable RCAs.
- `FIFO_DEPTH`, 8: configuration queue entries; power of two, ≥2.
- `ADDR_W`, 8: config address field width; covers the widest of grid/io/result/cpu-port addressing.
- `DATA_W`, 8: config data field width; covers the widest mux select or register address.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `cfg_valid` in 1: config request present.
- `cfg_ready` out 1: queue can accept.
- `cfg_kind` in 2: `CFG_CPU_REG`=0, `CFG_GRID_MUX`=1, `CFG_IO_MUX`=2, `CFG_RESULT_MUX`=3.
- `cfg_rca_sel` in clog2(NUM_RCAS): target RCA.
- `cfg_addr` in ADDR_W: entry address within the kind.
- `cfg_data` in DATA_W: new select / register address.
- `wr_hold` in 1: config regfile busy; do not pop.
- `wr_en` out 4: one-hot write enable, indexed by kind.
- `wr_rca_sel` out clog2(NUM_RCAS): RCA of the current write.
- `wr_addr` out ADDR_W: address of the current write.
- `wr_data` out DATA_W: data of the current write.
- `use_rca_sel` in clog2(NUM_RCAS): RCA queried by a pending use instruction.
- `use_ready` out 1: no outstanding config for `use_rca_sel`.
- `flush` in 1: discard all queued config (pipeline flush).
- `busy` out 1: queue non-empty or write in flight.

## Operation
- **Accept:**
  - An entry is pushed on a cycle with `cfg_valid && cfg_ready`.
  - `cfg_ready = !full && !flush && state==RUN`.
  - There is no bypass of a full queue.
- **Pop:**
  - An entry is popped when the queue is non-empty, `!wr_hold`, and `state==RUN`.
  - The popped entry is registered onto the `wr_*` outputs for exactly one cycle, with `wr_en[kind]`=1.
  - Otherwise `wr_en`=0 and `wr_rca_sel`/`wr_addr`/`wr_data` hold their last value.
- **Pending counters:** one per RCA, width clog2(FIFO_DEPTH+2).
  - +1 on accept for `cfg_rca_sel`.
  - −1 on the cycle `wr_en!=0` for `wr_rca_sel`.
  - Both events on the same RCA in the same cycle: no change.
- `use_ready = (pending[use_rca_sel]==0)`, combinational.
- **FSM:**
  - RUN: normal operation.
  - RUN→FLUSH when `flush`=1. The flush takes effect at that edge: queue pointers and all counters clear, and `wr_en` clears. Any entry being accepted or popped that cycle is discarded.
  - FLUSH→RUN after one cycle. While in FLUSH, `cfg_ready`=0 and `wr_en`=0.
- `busy = !empty || wr_en!=0`.
- **Reset:**
  - Pointers and counters clear; state RUN; `wr_en`=0; `wr_rca_sel`/`wr_addr`/`wr_data`=0.
  - `cfg_ready`=0 while `rst` is high.
  - A reset mid-drain discards all entries.
- **Pointers:** clog2(FIFO_DEPTH)+1 bits; full and empty are distinguished by the MSB; pointers wrap modulo 2·FIFO_DEPTH.

## Timing
- Accept at edge N → earliest `wr_en` in cycle N+1 (one-cycle latency when the queue is empty).
- Throughput: one write per cycle while `wr_hold`=0.
- `wr_hold`, when sampled high, suppresses the pop at that edge; `wr_en` is low in the following cycle.
- Full queue with a pop: `cfg_ready` stays 0 that cycle and rises the next cycle.
- `use_ready` for an RCA rises in the cycle after its final `wr_en` pulse.
- `flush` and `cfg_valid` in the same cycle: the entry is not accepted.

## Structure
- Shared package `rca_config_types`:
  - `rca_cfg_kind_t` enum.
  - `rca_cfg_entry_t` struct {kind, rca_sel, addr, data}.
  - `CFG_KIND_W`=2.
- Sub-module `rca_cfg_fifo`: parameterized, synchronous-reset FIFO with push/pop/full/empty/flush. The pending counters and FSM live in the top level.

## Test plan
- **Single entry:** reset, then push {GRID_MUX, rca 1, addr 0x05, data 0x03} → `wr_en`=4'b0010, `wr_rca_sel`=1, `wr_addr`=0x05, `wr_data`=0x03 one cycle later. `use_ready` for rca 1 is 0 for two cycles, then 1.
- **Fill and stall:** hold `wr_hold`=1 and push 8 entries → `cfg_ready`=0 after the 8th; pending[2]=8. Release `wr_hold` → 8 consecutive `wr_en` pulses in push order, and `cfg_ready` returns 1 the cycle after the first pop.
- **Back-to-back traffic:** continuous push with continuous drain across 20 entries (pointer wrap) → output order matches input and pending ends at 0.
- **Simultaneous accept and decrement:** push for rca 0 in the same cycle that `wr_en` retires an rca 0 entry → pending[0] is unchanged.
- **Flush mid-drain:** 5 entries queued and 2 written when `flush` is asserted → next cycle `wr_en`=0, `busy`=0, all `use_ready`=1, `cfg_ready`=0 for one cycle.
- **Reset mid-drain:** with `rst` high for 1 cycle → all outputs at reset values and no further `wr_en`.
